// File: rtl/dvp_pattern_source.sv
// dvp_pattern_source
// Synthetic OV7670-style parallel camera source. Emits RGB565 frames, two
// bytes per pixel with the MSB first, built from a selectable test pattern.
// All outputs change only on the pclk falling edge, so a receiver that samples
// on the rising edge always sees stable values.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   enable     request continuous frame output
//   patternSel 0 col, 1 {row,col}, 2 colour bars, 3 frame count
//   pclk       pixel clock, clk/(2*PCLK_DIV)
//   vsync      frame sync, active high
//   href       high during the active bytes of a line
//   data       pixel byte, 0 while href is low
//   frameDone  one-clk pulse at the end of each frame
//   frameCount number of completed frames, wraps
module dvp_pattern_source #(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int PCLK_DIV    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  patternSel,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frameDone,
    output logic [15:0] frameCount
);

    localparam int LINE   = 2 * H_ACTIVE + H_BLANK;
    localparam int HBYTES = 2 * H_ACTIVE;
    localparam int BAR_W  = H_ACTIVE / 8;
    localparam int H_W    = $clog2(LINE);
    localparam int DIV_W  = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam int BC_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_BACK,
        S_ACTIVE,
        S_FRONT
    } state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  div_cnt;
    logic [H_W-1:0]    hcnt, hcnt_n;     // byte period within the line
    logic [15:0]       lcnt, lcnt_n;     // line within the current state
    logic [1:0]        pat_q, pat_n;
    logic [15:0]       fc_snap, snap_n;  // frameCount latched at frame start
    logic [2:0]        bar_idx, bar_idx_n;
    logic [BC_W-1:0]   bar_cnt, bar_cnt_n;
    logic [15:0]       fc_n;
    logic [15:0]       lines_last;
    logic [15:0]       col_n;
    logic [15:0]       pix_n;
    logic              fall;
    logic              frame_end;
    logic              start_frame;
    logic              vsync_n, href_n;
    logic [7:0]        data_n;

    function automatic logic [15:0] bar_color(input logic [2:0] i);
        case (i)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    // The clk cycle whose closing edge drives pclk 1->0.
    assign fall = pclk && (div_cnt == DIV_W'(PCLK_DIV - 1));

    always_comb begin
        case (state)
            S_VSYNC:  lines_last = 16'(VSYNC_LINES - 1);
            S_BACK:   lines_last = 16'(V_BACK - 1);
            S_ACTIVE: lines_last = 16'(V_ACTIVE - 1);
            S_FRONT:  lines_last = 16'(V_FRONT - 1);
            default:  lines_last = 16'd0;
        endcase
    end

    // Next byte-period position. Everything advances only on a falling edge;
    // outputs are then derived from the position being entered.
    always_comb begin
        state_n     = state;
        hcnt_n      = hcnt;
        lcnt_n      = lcnt;
        pat_n       = pat_q;
        snap_n      = fc_snap;
        bar_idx_n   = bar_idx;
        bar_cnt_n   = bar_cnt;
        frame_end   = 1'b0;
        start_frame = 1'b0;

        if (fall) begin
            if (state == S_IDLE) begin
                start_frame = enable;
            end else if (hcnt != H_W'(LINE - 1)) begin
                hcnt_n = hcnt + 1'b1;
            end else begin
                hcnt_n = '0;
                if (lcnt != lines_last) begin
                    lcnt_n = lcnt + 16'd1;
                end else begin
                    lcnt_n = 16'd0;
                    case (state)
                        S_VSYNC:  state_n = S_BACK;
                        S_BACK:   state_n = S_ACTIVE;
                        S_ACTIVE: state_n = S_FRONT;
                        default: begin
                            frame_end   = 1'b1;
                            start_frame = enable;
                            state_n     = S_IDLE;
                        end
                    endcase
                end
            end
        end

        fc_n = frame_end ? frameCount + 16'd1 : frameCount;

        if (start_frame) begin
            state_n = S_VSYNC;
            hcnt_n  = '0;
            lcnt_n  = 16'd0;
            pat_n   = patternSel;
            snap_n  = fc_n;   // pattern 3 shows the count including this frame end
        end

        // Colour-bar index tracked incrementally: reset at each line start,
        // stepped every BAR_W pixels on the first byte of each new pixel.
        if (fall && state_n == S_ACTIVE && hcnt_n < H_W'(HBYTES)) begin
            if (hcnt_n == '0) begin
                bar_idx_n = 3'd0;
                bar_cnt_n = '0;
            end else if (!hcnt_n[0]) begin
                if (bar_cnt == BC_W'(BAR_W - 1)) begin
                    bar_cnt_n = '0;
                    bar_idx_n = bar_idx + 3'd1;
                end else begin
                    bar_cnt_n = bar_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        col_n = 16'(hcnt_n >> 1);
        case (pat_n)
            2'd0:    pix_n = col_n;
            2'd1:    pix_n = {lcnt_n[7:0], col_n[7:0]};
            2'd2:    pix_n = bar_color(bar_idx_n);
            default: pix_n = snap_n;
        endcase
        vsync_n = (state_n == S_VSYNC);
        href_n  = (state_n == S_ACTIVE) && (hcnt_n < H_W'(HBYTES));
        data_n  = 8'h00;
        if (href_n) begin
            data_n = hcnt_n[0] ? pix_n[7:0] : pix_n[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            pclk       <= 1'b0;
            state      <= S_IDLE;
            hcnt       <= '0;
            lcnt       <= 16'd0;
            pat_q      <= 2'd0;
            fc_snap    <= 16'd0;
            bar_idx    <= 3'd0;
            bar_cnt    <= '0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= 8'h00;
            frameDone  <= 1'b0;
            frameCount <= 16'd0;
        end else begin
            if (div_cnt == DIV_W'(PCLK_DIV - 1)) begin
                div_cnt <= '0;
                pclk    <= ~pclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            state      <= state_n;
            hcnt       <= hcnt_n;
            lcnt       <= lcnt_n;
            pat_q      <= pat_n;
            fc_snap    <= snap_n;
            bar_idx    <= bar_idx_n;
            bar_cnt    <= bar_cnt_n;
            frameDone  <= frame_end;
            frameCount <= fc_n;
            if (fall) begin
                vsync <= vsync_n;
                href  <= href_n;
                data  <= data_n;
            end
        end
    end

endmodule

// File: tb/tb_dvp_pattern_source.sv
// Bench for dvp_pattern_source with a small frame geometry (8x4 pixels,
// 18-period lines, 126-period frames, 252 clk per frame). The stimulus pushes
// the expected byte stream of each frame into a queue; a monitor pops one entry
// per href-high pclk period and compares it with data.
module tb_dvp_pattern_source;

    localparam int H_ACTIVE = 8, V_ACTIVE = 4, H_BLANK = 2;
    localparam int VSYNC_LINES = 1, V_BACK = 1, V_FRONT = 1, PCLK_DIV = 1;
    localparam int FRAME_CLK = 252;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  patternSel = 2'd0;
    logic        pclk, vsync, href, frameDone;
    logic [7:0]  data;
    logic [15:0] frameCount;

    int ntests = 0;
    int nfail  = 0;
    int cyc_now = 0;
    logic [7:0] q[$];

    dvp_pattern_source #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
        .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT),
        .PCLK_DIV(PCLK_DIV)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .patternSel(patternSel),
        .pclk(pclk), .vsync(vsync), .href(href), .data(data),
        .frameDone(frameDone), .frameCount(frameCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-written expected pixels for the 8x4 geometry.
    task automatic push_frame(input int pat, input logic [15:0] fc);
        logic [15:0] bars [0:7];
        logic [15:0] pix;
        bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
        bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;
        for (int r = 0; r < V_ACTIVE; r++) begin
            for (int c = 0; c < H_ACTIVE; c++) begin
                case (pat)
                    0:       pix = 16'(c);
                    1:       pix = {8'(r), 8'(c)};
                    2:       pix = bars[c];
                    default: pix = fc;
                endcase
                q.push_back(pix[15:8]);
                q.push_back(pix[7:0]);
            end
        end
    endtask

    // Monitor: one sample per pclk period, in the high phase.
    int mon_burst = 0, mon_bursts = 0, mon_vs = 0;
    logic mon_pl = 1'b0;
    logic [7:0] mon_exp;
    always @(negedge clk) begin
        if (reset) begin
            mon_pl = 1'b0; mon_burst = 0; mon_bursts = 0; mon_vs = 0;
        end else begin
            if (pclk && !mon_pl) begin
                if (href) begin
                    mon_burst++;
                    if (q.size() == 0) begin
                        chk("byte_unexpected", {24'd0, data}, 32'h1FF);
                    end else begin
                        mon_exp = q.pop_front();
                        chk("pixel_byte", {24'd0, data}, {24'd0, mon_exp});
                    end
                end else begin
                    if (mon_burst > 0) begin
                        chk("href_burst_len", mon_burst, 2 * H_ACTIVE);
                        mon_bursts++;
                        mon_burst = 0;
                    end
                    chk("data_when_href_low", {24'd0, data}, 32'd0);
                end
                if (vsync) begin
                    if (mon_vs == 0) mon_bursts = 0;
                    mon_vs++;
                end else if (mon_vs > 0) begin
                    chk("vsync_len", mon_vs, VSYNC_LINES * (2 * H_ACTIVE + H_BLANK));
                    mon_vs = 0;
                end
            end
            if (frameDone) chk("bursts_per_frame", mon_bursts, V_ACTIVE);
            mon_pl = pclk;
        end
    end

    // Returns the cycle stamp at which frameDone was seen, then checks it is a single clk.
    task automatic wait_frame_done(output int stamp);
        int n = 0;
        while (!frameDone && n < 1000) begin tick(); n++; end
        stamp = cyc_now;
        if (!frameDone) chk("frameDone_timeout", 32'd0, 32'd1);
        else begin
            tick();
            chk("frameDone_one_clk", {31'd0, frameDone}, 32'd0);
        end
    endtask

    task automatic wait_href_rise();
        int n = 0;
        logic prev = href;
        while (!(href && !prev) && n < 1000) begin prev = href; tick(); n++; end
        if (!href) chk("href_rise_timeout", 32'd0, 32'd1);
    endtask

    // Releases reset with enable high and checks vsync rises on clk 2.
    task automatic start_from_reset(output int stamp);
        reset = 1'b0; enable = 1'b1;
        tick();
        chk("pclk_first_rise", {31'd0, pclk}, 32'd1);
        chk("vsync_before_fall", {31'd0, vsync}, 32'd0);
        tick();
        chk("pclk_first_fall", {31'd0, pclk}, 32'd0);
        chk("vsync_rise_clk2", {31'd0, vsync}, 32'd1);
        stamp = cyc_now;
    endtask

    initial begin
        int t0, t1, toggles, idle_bad;
        logic pl, f;

        reset = 1'b1;
        repeat (3) tick();
        chk("rst_pclk", {31'd0, pclk}, 32'd0);
        chk("rst_vsync", {31'd0, vsync}, 32'd0);
        chk("rst_href", {31'd0, href}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_frameDone", {31'd0, frameDone}, 32'd0);
        chk("rst_frameCount", {16'd0, frameCount}, 32'd0);

        // Frames 1..3: pattern 0, then 1, then 3; patternSel changes mid-frame.
        patternSel = 2'd0;
        push_frame(0, 16'd0);
        start_from_reset(t0);
        patternSel = 2'd1;
        push_frame(1, 16'd1);
        wait_frame_done(t1);
        chk("frame1_len", t1 - t0, FRAME_CLK);
        chk("frame1_count", {16'd0, frameCount}, 32'd1);
        chk("vsync_after_done", {31'd0, vsync}, 32'd1);
        patternSel = 2'd3;
        push_frame(3, 16'd2);
        t0 = t1;
        wait_frame_done(t1);
        chk("frame2_len", t1 - t0, FRAME_CLK);
        chk("frame2_count", {16'd0, frameCount}, 32'd2);
        patternSel = 2'd2;
        push_frame(2, 16'd3);
        t0 = t1;
        wait_frame_done(t1);
        chk("frame3_len", t1 - t0, FRAME_CLK);
        chk("frame3_count", {16'd0, frameCount}, 32'd3);

        // Frame 4 (bars) is cut by a reset during its second active line.
        push_frame(2, 16'd3);
        wait_href_rise();
        wait_href_rise();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("midrst_pclk", {31'd0, pclk}, 32'd0);
        chk("midrst_vsync", {31'd0, vsync}, 32'd0);
        chk("midrst_href", {31'd0, href}, 32'd0);
        chk("midrst_data", {24'd0, data}, 32'd0);
        chk("midrst_frameDone", {31'd0, frameDone}, 32'd0);
        chk("midrst_frameCount", {16'd0, frameCount}, 32'd0);
        repeat (2) tick();
        q.delete();

        // Full bars frame after reset; enable dropped during row 1.
        push_frame(2, 16'd0);
        start_from_reset(t0);
        wait_href_rise();
        wait_href_rise();
        enable = 1'b0;
        wait_frame_done(t1);
        chk("bars_frame_len", t1 - t0, FRAME_CLK);
        chk("bars_frame_count", {16'd0, frameCount}, 32'd1);

        // Idle: syncs stay low, pclk keeps toggling.
        toggles = 0; idle_bad = 0; pl = pclk;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pclk != pl) toggles++;
            if (vsync || href || data != 8'h00) idle_bad++;
            pl = pclk;
        end
        chk("idle_pclk_toggles", toggles, 40);
        chk("idle_quiet", idle_bad, 0);
        chk("idle_count_held", {16'd0, frameCount}, 32'd1);

        // Preload the counter near its top to exercise the wrap.
        force dut.frameCount = 16'hFFFF;
        repeat (2) tick();
        release dut.frameCount;
        tick();
        chk("preload_count", {16'd0, frameCount}, 32'h0000FFFF);

        // Re-enable: vsync must rise on the very next falling edge.
        patternSel = 2'd3;
        push_frame(3, 16'hFFFF);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f = pclk;
            tick();
            if (f) begin
                chk("reenable_vsync_rise", {31'd0, vsync}, 32'd1);
                break;
            end
            chk("reenable_vsync_wait", {31'd0, vsync}, 32'd0);
        end
        t0 = cyc_now;
        enable = 1'b0;
        wait_frame_done(t1);
        chk("wrap_frame_len", t1 - t0, FRAME_CLK);
        chk("wrap_count", {16'd0, frameCount}, 32'd0);
        repeat (20) tick();
        chk("after_wrap_vsync", {31'd0, vsync}, 32'd0);
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
